// File: rtl/fifo_rd_stream_if.sv
// Signal bundle between the sync_fifo read port, the drainer and its valid/ready consumer.
// The master modport is the drainer's view; the slave modport is the view of the FIFO and consumer side.
interface fifo_rd_stream_if #(
  parameter int unsigned BITWID = 5
);
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [BITWID-1:0] fifo_rd_data;
  logic              fifo_rd_data_vld;
  logic              m_valid;
  logic              m_ready;
  logic [BITWID-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_rd_data, fifo_rd_data_vld, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_rd_data, fifo_rd_data_vld, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains sync_fifo into a valid/ready stream through a 2-entry skid buffer.
// FIFO pops are issued only when a buffer slot is guaranteed for the returning word.
module fifo_rd_stream #(
  parameter int unsigned BITWID = 5,
  parameter int unsigned CNTWID = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  fifo_rd_stream_if.master  bus,
  output logic [CNTWID-1:0] xfer_cnt,
  output logic              err
);
  localparam int unsigned BCW = 2;

  logic [BCW-1:0]    buf_cnt, buf_cnt_nxt;
  logic [BITWID-1:0] buf0, buf1, buf0_nxt, buf1_nxt;
  logic              inflight;
  logic              ign_vld;
  logic              m_valid_q;
  logic              err_nxt;
  logic [BCW-1:0]    occ;
  logic              pop, vld, capture, overflow, unexpected, rd_en;

  assign occ   = buf_cnt + BCW'(inflight);
  assign pop   = m_valid_q & bus.m_ready;
  assign rd_en = !rst & en & !bus.fifo_empty &
                 ((occ < BCW'(2)) | ((occ == BCW'(2)) & pop));

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = buf0;

  // Classify the returning word, then shift/append the in-order buffer (buf0 is the head).
  always_comb begin
    vld         = bus.fifo_rd_data_vld & !ign_vld;
    unexpected  = vld & !inflight;
    overflow    = vld & inflight & (buf_cnt == BCW'(2)) & !pop;
    capture     = vld & inflight & !overflow;
    buf0_nxt    = buf0;
    buf1_nxt    = buf1;
    buf_cnt_nxt = buf_cnt;
    err_nxt     = err | unexpected | overflow;
    case ({capture, pop})
      2'b01: begin
        buf0_nxt    = buf1;
        buf_cnt_nxt = buf_cnt - BCW'(1);
      end
      2'b10: begin
        if (buf_cnt == BCW'(0)) buf0_nxt = bus.fifo_rd_data;
        else                    buf1_nxt = bus.fifo_rd_data;
        buf_cnt_nxt = buf_cnt + BCW'(1);
      end
      2'b11: begin
        if (buf_cnt == BCW'(1)) begin
          buf0_nxt = bus.fifo_rd_data;
        end else begin
          buf0_nxt = buf1;
          buf1_nxt = bus.fifo_rd_data;
        end
      end
      default: ;
    endcase
  end

  // ign_vld masks a stale return from a pop issued before reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_cnt   <= '0;
      buf0      <= '0;
      buf1      <= '0;
      inflight  <= 1'b0;
      ign_vld   <= 1'b1;
      m_valid_q <= 1'b0;
      xfer_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      buf_cnt   <= buf_cnt_nxt;
      buf0      <= buf0_nxt;
      buf1      <= buf1_nxt;
      inflight  <= rd_en;
      ign_vld   <= 1'b0;
      m_valid_q <= (buf_cnt_nxt != BCW'(0));
      xfer_cnt  <= xfer_cnt + CNTWID'(pop);
      err       <= err_nxt;
    end
  end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: behavioural sync_fifo read port plus handshake monitor.
module tb_fifo_rd_stream;
  localparam int unsigned BW = 5;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          en  = 1'b1;
  logic [CW-1:0] xfer_cnt;
  logic          err;

  fifo_rd_stream_if #(.BITWID(BW)) bus ();

  fifo_rd_stream #(.BITWID(BW), .CNTWID(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus), .xfer_cnt(xfer_cnt), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // FIFO model: pop returns data with vld one cycle later; reset flushes it.
  logic [BW-1:0] mem [0:255];
  int            wr_ptr   = 0;
  int            rd_ptr   = 0;
  logic          mdl_vld  = 1'b0;
  logic [BW-1:0] mdl_data = '0;
  logic          inj_vld  = 1'b0;
  logic [BW-1:0] inj_data = '0;

  assign bus.fifo_empty       = (rd_ptr == wr_ptr);
  assign bus.fifo_rd_data_vld = mdl_vld | inj_vld;
  assign bus.fifo_rd_data     = inj_vld ? inj_data : mdl_data;

  always @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= wr_ptr;
      mdl_vld <= 1'b0;
    end else begin
      mdl_vld <= 1'b0;
      if (bus.fifo_rd_en && (rd_ptr != wr_ptr)) begin
        mdl_data <= mem[rd_ptr];
        mdl_vld  <= 1'b1;
        rd_ptr   <= rd_ptr + 1;
      end
    end
  end

  // Monitor: cycle stamps of pops and output handshakes.
  int            cyc        = 0;
  int            rd_n       = 0;
  int            out_n      = 0;
  int            rd_empty_n = 0;
  int            rd_cyc  [0:255];
  int            out_cyc [0:255];
  logic [BW-1:0] out_val [0:255];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fifo_rd_en === 1'b1) begin
      rd_cyc[rd_n] <= cyc;
      rd_n         <= rd_n + 1;
      if (bus.fifo_empty) rd_empty_n <= rd_empty_n + 1;
    end
    if ((bus.m_valid === 1'b1) && (bus.m_ready === 1'b1)) begin
      out_val[out_n] <= bus.m_data;
      out_cyc[out_n] <= cyc;
      out_n          <= out_n + 1;
    end
  end

  task automatic push(input logic [BW-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr      = wr_ptr + 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.m_valid !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: m_valid=%b fifo_rd_en=%b, want 0 0", i, bus.m_valid, bus.fifo_rd_en);
      end
      n_tests++;
      if (xfer_cnt !== '0 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: xfer_cnt=%0d err=%b, want 0 0", i, xfer_cnt, err);
      end
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.m_valid !== 1'b0 || bus.fifo_rd_en !== 1'b0 || xfer_cnt !== '0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: m_valid=%b rd_en=%b xfer_cnt=%0d err=%b, want 0 0 0 0",
               bus.m_valid, bus.fifo_rd_en, xfer_cnt, err);
    end
  endtask

  task automatic test_single();
    int c0, rb, ob;
    @(negedge clk);
    c0 = cyc; rb = rd_n; ob = out_n;
    push(5'h15);
    #1;
    n_tests++;
    if (bus.fifo_rd_en !== 1'b1) begin
      n_fail++; $display("FAIL single_rd_en_t: got %b want 1", bus.fifo_rd_en);
    end
    @(negedge clk);
    n_tests++;
    if (bus.fifo_rd_en !== 1'b0 || bus.m_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_t1: rd_en=%b m_valid=%b want 0 0", bus.fifo_rd_en, bus.m_valid);
    end
    @(negedge clk);
    n_tests++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 5'h15) begin
      n_fail++; $display("FAIL single_t2: m_valid=%b m_data=%h want 1 15", bus.m_valid, bus.m_data);
    end
    @(negedge clk);
    n_tests++;
    if (bus.m_valid !== 1'b0 || xfer_cnt !== CW'(1) || (rd_n - rb) != 1 || (out_n - ob) != 1 || out_cyc[ob] != c0 + 2) begin
      n_fail++;
      $display("FAIL single_done: m_valid=%b xfer=%0d rds=%0d outs=%0d lat=%0d want 0 1 1 1 2",
               bus.m_valid, xfer_cnt, rd_n - rb, out_n - ob, out_cyc[ob] - c0);
    end
  endtask

  task automatic test_streaming();
    int c0, rb, ob;
    @(negedge clk);
    c0 = cyc; rb = rd_n; ob = out_n;
    for (int i = 1; i <= 8; i++) push(BW'(i));
    for (int k = 0; k < 30 && (out_n - ob) < 8; k++) @(negedge clk);
    n_tests++;
    if ((out_n - ob) != 8 || (rd_n - rb) != 8) begin
      n_fail++; $display("FAIL stream_count: outs=%0d rds=%0d want 8 8", out_n - ob, rd_n - rb);
    end
    n_tests++;
    if (rd_cyc[rb] != c0 || rd_cyc[rb+7] != c0 + 7) begin
      n_fail++; $display("FAIL stream_rd_timing: first=%0d last=%0d want %0d %0d", rd_cyc[rb], rd_cyc[rb+7], c0, c0 + 7);
    end
    n_tests++;
    if (out_cyc[ob] != c0 + 2 || out_cyc[ob+7] != c0 + 9) begin
      n_fail++; $display("FAIL stream_out_timing: first=%0d last=%0d want %0d %0d", out_cyc[ob], out_cyc[ob+7], c0 + 2, c0 + 9);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (out_val[ob+i] !== BW'(i + 1)) begin
        n_fail++; $display("FAIL stream_data[%0d]: got %0d want %0d", i, out_val[ob+i], i + 1);
      end
    end
    n_tests++;
    if (xfer_cnt !== CW'(9) || bus.fifo_empty !== 1'b1) begin
      n_fail++; $display("FAIL stream_end: xfer_cnt=%0d fifo_empty=%b want 9 1", xfer_cnt, bus.fifo_empty);
    end
  endtask

  task automatic test_backpressure();
    int rb, ob, unstable;
    @(negedge clk);
    bus.m_ready = 1'b0;
    rb = rd_n; ob = out_n; unstable = 0;
    for (int i = 1; i <= 8; i++) push(BW'(i));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.m_valid === 1'b1 && bus.m_data !== 5'd1) unstable++;
    end
    n_tests++;
    if ((rd_n - rb) != 2 || (out_n - ob) != 0) begin
      n_fail++; $display("FAIL bp_reads: rds=%0d outs=%0d want 2 0", rd_n - rb, out_n - ob);
    end
    n_tests++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 5'd1 || unstable != 0) begin
      n_fail++; $display("FAIL bp_hold: m_valid=%b m_data=%0d unstable=%0d want 1 1 0", bus.m_valid, bus.m_data, unstable);
    end
    bus.m_ready = 1'b1;
    for (int k = 0; k < 30 && (out_n - ob) < 8; k++) @(negedge clk);
    n_tests++;
    if ((out_n - ob) != 8) begin
      n_fail++; $display("FAIL bp_count: outs=%0d want 8", out_n - ob);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (out_val[ob+i] !== BW'(i + 1)) begin
        n_fail++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, out_val[ob+i], i + 1);
      end
    end
    n_tests++;
    if (err !== 1'b0 || xfer_cnt !== CW'(17)) begin
      n_fail++; $display("FAIL bp_end: err=%b xfer_cnt=%0d want 0 %0d", err, xfer_cnt, 17 % 16);
    end
  endtask

  task automatic test_en_gating();
    int rb, ob;
    @(negedge clk);
    rb = rd_n; ob = out_n;
    for (int i = 1; i <= 8; i++) push(BW'(10 + i));
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    n_tests++;
    if ((rd_n - rb) != 3 || (out_n - ob) != 3 || bus.fifo_rd_en !== 1'b0 || bus.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL en_gate: rds=%0d outs=%0d rd_en=%b m_valid=%b want 3 3 0 0",
               rd_n - rb, out_n - ob, bus.fifo_rd_en, bus.m_valid);
    end
    n_tests++;
    if (out_val[ob] !== 5'd11 || out_val[ob+1] !== 5'd12 || out_val[ob+2] !== 5'd13) begin
      n_fail++; $display("FAIL en_data: got %0d %0d %0d want 11 12 13", out_val[ob], out_val[ob+1], out_val[ob+2]);
    end
    n_tests++;
    if (xfer_cnt !== CW'(20)) begin
      n_fail++; $display("FAIL en_xfer: got %0d want %0d", xfer_cnt, 20 % 16);
    end
  endtask

  task automatic test_mid_reset();
    bus.m_ready = 1'b0;
    en = 1'b1;
    repeat (6) @(negedge clk);
    n_tests++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 5'd14) begin
      n_fail++; $display("FAIL mr_pre: m_valid=%b m_data=%0d want 1 14", bus.m_valid, bus.m_data);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.m_valid !== 1'b0 || xfer_cnt !== '0 || err !== 1'b0) begin
      n_fail++; $display("FAIL mr_reset: m_valid=%b xfer=%0d err=%b want 0 0 0", bus.m_valid, xfer_cnt, err);
    end
    rst = 1'b0;
    bus.m_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if (bus.m_valid !== 1'b0 || err !== 1'b0 || xfer_cnt !== '0) begin
      n_fail++; $display("FAIL mr_after: m_valid=%b err=%b xfer=%0d want 0 0 0", bus.m_valid, err, xfer_cnt);
    end
  endtask

  task automatic test_error();
    int ob;
    @(negedge clk);
    inj_data = 5'h1f;
    inj_vld  = 1'b1;
    @(negedge clk);
    inj_vld = 1'b0;
    n_tests++;
    if (err !== 1'b1 || bus.m_valid !== 1'b0) begin
      n_fail++; $display("FAIL err_set: err=%b m_valid=%b want 1 0", err, bus.m_valid);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (err !== 1'b1 || bus.m_valid !== 1'b0 || xfer_cnt !== '0) begin
      n_fail++; $display("FAIL err_sticky: err=%b m_valid=%b xfer=%0d want 1 0 0", err, bus.m_valid, xfer_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: err=%b want 0", err);
    end
    // Unexpected word while a word is held must not disturb the buffer.
    bus.m_ready = 1'b0;
    ob = out_n;
    push(5'h0a);
    repeat (3) @(negedge clk);
    inj_vld = 1'b1;
    @(negedge clk);
    inj_vld = 1'b0;
    n_tests++;
    if (err !== 1'b1 || bus.m_valid !== 1'b1 || bus.m_data !== 5'h0a) begin
      n_fail++; $display("FAIL err_buf: err=%b m_valid=%b m_data=%h want 1 1 0a", err, bus.m_valid, bus.m_data);
    end
    bus.m_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if ((out_n - ob) != 1 || out_val[ob] !== 5'h0a || xfer_cnt !== CW'(1) || err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_drain: outs=%0d data=%h xfer=%0d err=%b want 1 0a 1 1", out_n - ob, out_val[ob], xfer_cnt, err);
    end
  endtask

  initial begin
    bus.m_ready = 1'b1;
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_en_gating();
    test_mid_reset();
    test_error();
    n_tests++;
    if (rd_empty_n != 0) begin
      n_fail++; $display("FAIL rd_en_while_empty: count=%0d want 0", rd_empty_n);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
